// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
// Holds the fetch FSM state encoding, the queue entry layout at default
// widths, and the default DEPTH / PC / instruction widths.
package fetch_pkg;

    localparam int FETCH_DEPTH = 4;
    localparam int PC_W        = 8;
    localparam int INSTR_W     = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

    // One queued instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: circular-buffer queue with push, pop and flush, used as the fetch prefetch buffer.
// Latency: a word pushed at one edge is readable at rdata_o right after that edge.
// Backpressure: the caller gates push on full_o (or a same-cycle pop); pop on empty is ignored.
//
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-low reset
//   push_i, wdata_i  - write wdata_i at the tail
//   pop_i            - advance the head
//   flush_i          - drop every entry (beats push and pop)
//   rdata_o          - head word, straight from the storage array
//   full_o, empty_o  - occupancy flags
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A pop on an empty queue must not move the head.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count_q > 0.
    always_ff @(posedge clock) begin
        if (reset && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Purpose: fetch stage owning the fetch pointer; prefetches ROM words into a queue for the decoder.
// Latency: ROM word pushed at edge N is presented to the decoder after edge N; redirect costs one bubble.
// Backpressure: instr_ready low holds the head; fetching pauses while the queue is full.
//
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-low reset
//   fetch_en                - run/halt new ROM reads
//   mem_addr / mem_data     - combinational ROM port (registered address)
//   instr_valid/instr/instr_pc, instr_ready - decoder handshake
//   redirect, redirect_pc   - taken branch: flush queue, restart at target
//   stall_cycles            - only with FETCH_STALL_CNT_EN: saturating count of
//                             cycles where the decoder was ready but starved
module instr_fetch_queue #(
    parameter int DEPTH   = fetch_pkg::FETCH_DEPTH,
    parameter int ADDR_W  = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    import fetch_pkg::*;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_active;
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic              pop;
    entry_t            wr_entry;
    entry_t            head;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // A redirect freezes the state for that edge.
    always_comb begin
        state_d = state_q;
        if (!redirect) begin
            case (state_q)
                S_IDLE:  state_d = fetch_en ? S_RUN : S_IDLE;
                S_RUN:   state_d = fetch_en ? S_RUN : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fetch_active = 1'b0;
        case (state_q)
            S_RUN:   fetch_active = 1'b1;
            default: fetch_active = 1'b0;
        endcase
    end

    // ---------------- handshake and queue control ----------------
    assign instr_valid = !q_empty;

    // Redirect wins: neither the decoder's accept nor the ROM read lands.
    // A same-cycle pop frees the slot, so a full queue still streams.
    assign pop  = instr_valid && instr_ready && !redirect;
    assign push = fetch_active && !redirect && (!q_full || pop);

    assign wr_entry = '{instr: mem_data, pc: pc_q};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Stale array contents must never leak onto the decoder bus.
    assign instr    = instr_valid ? head.instr : '0;
    assign instr_pc = instr_valid ? head.pc    : '0;

    // ---------------- fetch pointer ----------------
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign mem_addr = pc_q;

`ifdef FETCH_STALL_CNT_EN
    // ---------------- decoder starvation counter ----------------
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (instr_ready && !instr_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    logic [15:0] rom [256];
    assign mem_data = rom[mem_addr];

    instr_fetch_queue #(
        .DEPTH   (DEPTH),
        .ADDR_W  (8),
        .INSTR_W (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_err  = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    // Queue of {instr, pc}; running mirrors "fetching is on".
    logic [23:0] mq[$];
    bit          m_run   = 1'b0;
    logic [7:0]  m_fp    = 8'h00;
    logic [15:0] m_stall = 16'h0000;

    always @(posedge clock) begin
        bit do_pop;
        bit do_push;
        if (!reset) begin
            mq.delete();
            m_run   = 1'b0;
            m_fp    = 8'h00;
            m_stall = 16'h0000;
        end else begin
            if (instr_ready && mq.size() == 0 && m_stall != 16'hFFFF)
                m_stall = m_stall + 16'd1;
            if (redirect) begin
                mq.delete();
                m_fp = redirect_pc;
            end else begin
                do_pop  = (mq.size() > 0) && instr_ready;
                do_push = m_run && ((mq.size() < DEPTH) || do_pop);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back({rom[m_fp], m_fp});
                    m_fp = m_fp + 8'd1;
                end
                m_run = fetch_en;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_valid", 32'(instr_valid), 32'(mq.size() > 0));
            chk("m_instr", 32'(instr), (mq.size() > 0) ? 32'(mq[0][23:8]) : 32'd0);
            chk("m_pc", 32'(instr_pc), (mq.size() > 0) ? 32'(mq[0][7:0]) : 32'd0);
            chk("m_addr", 32'(mem_addr), 32'(m_fp));
`ifdef FETCH_STALL_CNT_EN
            chk("m_stall", 32'(stall_cycles), 32'(m_stall));
`endif
        end
    end

    task automatic drive(input logic r, input logic f, input logic rd,
                         input logic rdr, input logic [7:0] rpc);
        reset       = r;
        fetch_en    = f;
        instr_ready = rd;
        redirect    = rdr;
        redirect_pc = rpc;
        n_vec++;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'hA000; rom[1] = 16'hA101; rom[2] = 16'hA202;
        rom[3] = 16'hA303; rom[4] = 16'hA404; rom[5] = 16'hA505;
        rom[8'h40] = 16'hC040;

        @(negedge clock);
        // ---- reset fill ----
        drive(0, 1, 1, 0, 8'h00);
        chk_en = 1'b1;
        drive(0, 1, 1, 0, 8'h00);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        drive(1, 1, 1, 0, 8'h00);               // edge 1: enter S_RUN
        chk("fill_e1_valid", 32'(instr_valid), 32'd0);
        drive(1, 1, 1, 0, 8'h00);               // edge 2: push address 0
        chk("fill_e2_valid", 32'(instr_valid), 32'd1);
        chk("fill_e2_instr", 32'(instr), 32'hA000);
        chk("fill_e2_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_first", 32'(stall_cycles), 32'd2);
`endif
        drive(1, 1, 1, 0, 8'h00);
        chk("fill_e3_instr", 32'(instr), 32'hA101);
        chk("fill_e3_pc", 32'(instr_pc), 32'd1);
        drive(1, 1, 1, 0, 8'h00);
        chk("fill_e4_instr", 32'(instr), 32'hA202);

        // ---- backpressure from a fresh reset ----
        drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 8'h00);
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_head", 32'(instr), 32'hA000);
        chk("bp_addr", 32'(mem_addr), 32'd4);
        drive(1, 1, 1, 0, 8'h00);               // pop and push while full
        chk("bp_rel_head", 32'(instr), 32'hA101);
        chk("bp_rel_addr", 32'(mem_addr), 32'd5);
        drive(1, 1, 1, 0, 8'h00);
        chk("bp_rel2_head", 32'(instr), 32'hA202);

        // ---- redirect while full and decoder ready ----
        drive(1, 1, 1, 1, 8'h40);
        chk("rdr_valid", 32'(instr_valid), 32'd0);
        chk("rdr_addr", 32'(mem_addr), 32'h40);
        drive(1, 1, 1, 0, 8'h00);
        chk("rdr_tgt_valid", 32'(instr_valid), 32'd1);
        chk("rdr_tgt_instr", 32'(instr), 32'hC040);
        chk("rdr_tgt_pc", 32'(instr_pc), 32'h40);

        // ---- wrap-around ----
        drive(1, 1, 1, 1, 8'hFE);
        drive(1, 1, 1, 0, 8'h00);
        chk("wrap_pc0", 32'(instr_pc), 32'hFE);
        drive(1, 1, 1, 0, 8'h00);
        chk("wrap_pc1", 32'(instr_pc), 32'hFF);
        drive(1, 1, 1, 0, 8'h00);
        chk("wrap_pc2", 32'(instr_pc), 32'h00);
        drive(1, 1, 1, 0, 8'h00);
        chk("wrap_pc3", 32'(instr_pc), 32'h01);

        // ---- reset mid-operation with 3 entries and redirect high ----
        drive(1, 1, 0, 1, 8'h10);               // empty the queue, stay in S_RUN
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 8'h00);
        chk("mid_pre_valid", 32'(instr_valid), 32'd1);
        drive(0, 1, 1, 1, 8'h40);
        chk("mid_valid", 32'(instr_valid), 32'd0);
        chk("mid_instr", 32'(instr), 32'd0);
        chk("mid_pc", 32'(instr_pc), 32'd0);
        chk("mid_addr", 32'(mem_addr), 32'd0);
        drive(1, 1, 1, 0, 8'h00);
        chk("mid_idle_valid", 32'(instr_valid), 32'd0);
        drive(1, 1, 1, 0, 8'h00);
        chk("mid_refill_instr", 32'(instr), 32'hA000);
        chk("mid_refill_pc", 32'(instr_pc), 32'd0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 2000; i++) begin
            drive(logic'($urandom_range(0, 99) != 0),
                  logic'($urandom_range(0, 9) != 0),
                  logic'($urandom_range(0, 2) != 0),
                  logic'($urandom_range(0, 15) == 0),
                  8'($urandom));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage placed between the program ROM and the instruction decoder. It owns the fetch pointer, prefetches instruction words from the combinational program ROM into a small FIFO, and presents them to the decoder with a valid/ready handshake. Taken branches are delivered as a redirect that flushes the queue and restarts fetching at the target address.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2 to 16.
- `ADDR_W`, 8: program address width.
- `INSTR_W`, 16: instruction word width.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `fetch_en` in 1: fetch enable; low halts new ROM reads.
- `mem_addr` out ADDR_W: ROM read address, equal to the registered fetch pointer.
- `mem_data` in INSTR_W: ROM read data, valid in the same cycle as `mem_addr`.
- `instr_valid` out 1: the head entry is valid.
- `instr` out INSTR_W: head instruction word.
- `instr_pc` out ADDR_W: address the head instruction was fetched from.
- `instr_ready` in 1: the decoder accepts the head entry this cycle.
- `redirect` in 1: a branch was taken; flush and refetch.
- `redirect_pc` in ADDR_W: branch target address.
- `stall_cycles` out 16: present only with `FETCH_STALL_CNT_EN` (see Configuration).

## Operation
- The FSM has two states:
  - `S_IDLE`: reset state; no ROM reads.
  - `S_RUN`: fetching.
- FSM transitions:
  - `S_IDLE` → `S_RUN` when `fetch_en`=1.
  - `S_RUN` → `S_IDLE` when `fetch_en`=0.
  - Entries already queued remain poppable in `S_IDLE`.
- Push condition: state is `S_RUN` AND `redirect`=0 AND (count < DEPTH OR pop this cycle).
- On a push:
  - The queue captures {`mem_data`, `mem_addr`} at the tail.
  - The fetch pointer increments modulo 2^ADDR_W, so 255 wraps to 0.
- Pop condition: `instr_valid` AND `instr_ready`. On a pop the head advances.
- Simultaneous push and pop, including when the queue is full: both occur and the count is unchanged.
- A pop on an empty queue is ignored. `instr_ready` is don't-care when `instr_valid`=0.
- Redirect has the highest priority. When `redirect`=1, on the next edge:
  - the count clears to 0 and the head and tail pointers reset;
  - the fetch pointer loads `redirect_pc`;
  - no push and no pop take effect, even if `instr_ready`=1;
  - the FSM state is unchanged.
- `reset`=0 at an edge, which dominates `redirect`, sets:
  - state to `S_IDLE`;
  - fetch pointer, count and pointers to 0;
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `mem_addr`=0.
- A reset in the middle of operation discards all queued entries.
- `instr` and `instr_pc` are 0 whenever `instr_valid`=0.

## Timing
- ROM read latency is 0: `mem_data` is sampled at the same edge that advances `mem_addr`.
- Fill latency: an instruction pushed at edge N is visible with `instr_valid`=1 after edge N. This gives one cycle from ROM to decoder.
- First valid instruction: `reset` is released with `fetch_en`=1 at edge 0.
  - Edge 1 enters `S_RUN`.
  - Edge 2 pushes address 0.
  - `instr_valid` rises after edge 2.
- Redirect penalty: `redirect` is high at edge N.
  - `instr_valid`=0 after edge N.
  - The target instruction is valid after edge N+1.
- Steady state with `instr_ready` held at 1: throughput is one instruction per cycle with no bubbles.
- The head outputs are driven directly from registers and the entry array, with no combinational path from `instr_ready` to `instr_valid`.
- `mem_addr` is registered.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - adds the `stall_cycles` port;
  - `stall_cycles` increments each cycle in which `instr_ready`=1 and `instr_valid`=0, saturating at 16'hFFFF;
  - `stall_cycles` clears on reset only.
- `FETCH_STALL_CNT_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state enum {`S_IDLE`, `S_RUN`};
  - the entry struct {instr, pc};
  - the default constants `FETCH_DEPTH`=4, `PC_W`=8 and `INSTR_W`=16.
- Sub-module `fetch_fifo`:
  - parameterised storage with pointers and count;
  - push, pop and flush inputs;
  - full and empty outputs.
- The top level holds the FSM, the fetch pointer, the redirect logic and the optional counter.

## Test plan
- Reset fill:
  - Stimulus: ROM[0..3]=A000,A101,A202,A303; `fetch_en`=1; `instr_ready`=1 after the reset release.
  - Required response: `instr_valid` rises after the 2nd edge, then A000/pc 0, A101/pc 1 and so on, one per cycle.
- Backpressure:
  - Stimulus: `instr_ready`=0 for 10 cycles.
  - Required response: count saturates at 4, `mem_addr` holds at 4, the head stays A000, and no entry is lost or duplicated after `instr_ready` returns to 1.
- Redirect:
  - Stimulus: `redirect`=1 with `redirect_pc`=8'h40 while the queue is full and `instr_ready`=1.
  - Required response: no pop occurs, `instr_valid`=0 the next cycle, and the following instruction is ROM[40] with `instr_pc`=40.
- Wrap-around:
  - Stimulus: redirect to 8'hFE and free-run.
  - Required response: `instr_pc` sequence FE, FF, 00, 01.
- Reset mid-operation:
  - Stimulus: `reset`=0 for one edge while the queue holds 3 entries and `redirect`=1.
  - Required response: all outputs are 0 and the state is `S_IDLE`; the fill restarts from address 0.
- Stall counter (with `FETCH_STALL_CNT_EN`):
  - Stimulus: after reset, `instr_ready`=1.
  - Required response: `stall_cycles`=2 when the first instruction becomes valid.
